// File: rtl/div_rr_sequencer.sv
// div_rr_sequencer: two requesters share one iterative restoring divider.
// A round-robin arbiter accepts one operation at a time. The divider runs N
// shift-subtract steps, one per clock. The result is then held on a
// valid/ready response port until the consumer takes it.
//
// Handshake semantics: a transfer happens on a rising clk edge where valid
// and ready are both high. reqX_ready is a combinational function of state,
// the rr pointer and the request valids. rsp_valid is registered and does not
// depend on rsp_ready. While rsp_valid is high, rsp_* payloads stay constant.
module div_rr_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_q,
  output logic [N-1:0] rsp_r,
  output logic         rsp_dbz,
  output logic [1:0]   o_dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    r_state;
  logic          r_rr;
  logic          r_id;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_b;
  logic          r_rsp_id;
  logic [N-1:0]  r_rsp_q;
  logic [N-1:0]  r_rsp_r;
  logic          r_rsp_dbz;

  logic          w_idle;
  logic          w_accept;
  logic          w_grant;
  logic [N-1:0]  w_a;
  logic [N-1:0]  w_b;
  logic [N:0]    w_trial;
  logic [N:0]    w_diff;
  logic          w_ge;
  logic [N:0]    w_rem_full;
  logic [N-1:0]  w_rem_next;
  logic [N-1:0]  w_quo_next;
  logic          w_unused;

  // Arbitration. A lone valid requester wins. With both valid, the rr pointer decides.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_grant    = (req0_valid && req1_valid) ? r_rr : req1_valid;
  assign w_accept   = w_idle && (req0_valid || req1_valid);
  assign req0_ready = w_accept && !w_grant;
  assign req1_ready = w_accept && w_grant;
  assign w_a        = w_grant ? req1_a : req0_a;
  assign w_b        = w_grant ? req1_b : req0_b;

  // Restoring step. The N+1-bit trial cannot overflow. The kept remainder is always < b, so it fits N bits.
  assign w_trial    = {r_rem, r_quo[N-1]};
  assign w_diff     = w_trial - {1'b0, r_b};
  assign w_ge       = (w_trial >= {1'b0, r_b});
  assign w_rem_full = w_ge ? w_diff : w_trial;
  assign w_rem_next = w_rem_full[N-1:0];
  assign w_quo_next = {r_quo[N-2:0], w_ge};
  assign w_unused   = w_rem_full[N];

  assign rsp_valid   = (r_state == ST_DONE);
  assign rsp_id      = r_rsp_id;
  assign rsp_q       = r_rsp_q;
  assign rsp_r       = r_rsp_r;
  assign rsp_dbz     = r_rsp_dbz;
  assign o_dbg_state = r_state;

  // Sequencer FSM. It covers accept/latch, the iterative divide and response hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rr      <= 1'b0;
      r_id      <= 1'b0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_b       <= '0;
      r_rsp_id  <= 1'b0;
      r_rsp_q   <= '0;
      r_rsp_r   <= '0;
      r_rsp_dbz <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rr <= ~w_grant;
            r_id <= w_grant;
            if (w_b != '0) begin
              r_rem   <= '0;
              r_quo   <= w_a;
              r_b     <= w_b;
              r_cnt   <= CNT_LOAD;
              r_state <= ST_RUN;
            end else begin
              // Divide by zero skips the datapath entirely.
              r_rsp_q   <= '1;
              r_rsp_r   <= w_a;
              r_rsp_dbz <= 1'b1;
              r_rsp_id  <= w_grant;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_rsp_q   <= w_quo_next;
            r_rsp_r   <= w_rem_next;
            r_rsp_dbz <= 1'b0;
            r_rsp_id  <= r_id;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_rr_sequencer.sv
// Testbench for div_rr_sequencer (N=4). It uses directed vectors with hand-computed results.
// Requests push expected responses into exp_q when they are accepted. A monitor pops
// and compares on every response handshake.
module tb_div_rr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_dbz;
  logic [3:0] rsp_q, rsp_r;
  logic [1:0] dbg_state;

  logic [9:0] exp_q[$];   // {id, q, r, dbz}
  int         acc_ids[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         t4_done;

  div_rr_sequencer #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dbz(rsp_dbz), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // driver: present a request, wait for its accept, then drop valid after the accept edge
  task automatic issue(input logic id, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] eq, input logic [3:0] er, input logic edbz,
                       input logic push);
    int waited = 0;
    bit got = 0;
    if (id == 1'b0) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else            begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    while (!got && waited < 200) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        got = 1;
        acc_ids.push_back(int'(id));
        if (push) exp_q.push_back({id, eq, er, edbz});
      end
      waited++;
    end
    @(posedge clk);
    #1;
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    check("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || rsp_valid) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", 32'(k < 100), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int k = 0;
    bit seen = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (rsp_valid) seen = 1;
    end
    check(name, 32'(k), 32'(exp_lat));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d q=%0h r=%0h dbz=%0d, required no response",
                 rsp_id, rsp_q, rsp_r, rsp_dbz);
      end else begin
        e = exp_q.pop_front();
        check("rsp_payload", {22'd0, rsp_id, rsp_q, rsp_r, rsp_dbz}, {22'd0, e});
      end
    end
  end

  // protocol watchers: never both ready, never ready while a response is pending
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_mutex", 32'(req0_ready && req1_ready), 32'd0);
      check("ready_in_done", 32'(rsp_valid && (req0_ready || req1_ready)), 32'd0);
    end
  end

  initial begin
    int exp_order[4];
    int idx;
    exp_order = '{0, 1, 0, 1};
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    // reset state
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_q", 32'(rsp_q), 32'd0);
    check("rst_r", 32'(rsp_r), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_dbz", 32'(rsp_dbz), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single request 13/3
    issue(1'b0, 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);
    wait_valid("t1_latency", 5);
    drain();

    // 2: both valid continuously after reset -> 0,1,0,1
    do_reset();
    acc_ids.delete();
    fork
      begin
        issue(1'b0, 4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 1'b1);
        issue(1'b0, 4'd5, 4'd5, 4'd1, 4'd0, 1'b0, 1'b1);
      end
      begin
        issue(1'b1, 4'd6, 4'd4, 4'd1, 4'd2, 1'b0, 1'b1);
        issue(1'b1, 4'd15, 4'd2, 4'd7, 4'd1, 1'b0, 1'b1);
      end
    join
    drain();
    check("t2_accept_count", 32'(acc_ids.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_ids.size()) check("t2_grant_order", 32'(acc_ids[i]), 32'(exp_order[i]));
    end

    // 3: divide by zero on requester 1
    issue(1'b1, 4'd9, 4'd0, 4'hF, 4'd9, 1'b1, 1'b1);
    wait_valid("t3_latency", 1);
    drain();

    // 4: back-pressure, response stable, pending req0 waits past the handshake
    rsp_ready = 1'b0;
    issue(1'b1, 4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 1'b1);
    wait_valid("t4_latency", 5);
    t4_done = 0;
    fork
      begin
        issue(1'b0, 4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b1);
        t4_done = 1;
      end
    join_none
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      check("t4_hold_valid", 32'(rsp_valid), 32'd1);
      check("t4_hold_payload", {22'd0, rsp_id, rsp_q, rsp_r, rsp_dbz}, {22'd0, 1'b1, 4'd3, 4'd2, 1'b0});
      check("t4_no_accept", 32'(req0_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_no_accept_on_handshake", 32'(req0_ready), 32'd0);
    @(negedge clk);
    check("t4_accept_next_cycle", 32'(req0_ready), 32'd1);
    for (int k = 0; k < 50 && !t4_done; k++) @(posedge clk);
    check("t4_issue_done", 32'(t4_done), 32'd1);
    drain();

    // 5: reset during RUN step 2 aborts; fresh op afterwards
    issue(1'b0, 4'd10, 4'd3, 4'd3, 4'd1, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_q", 32'(rsp_q), 32'd0);
    check("t5_rst_r", 32'(rsp_r), 32'd0);
    check("t5_rst_dbz", 32'(rsp_dbz), 32'd0);
    check("t5_rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t5_no_stale_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    issue(1'b0, 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 1'b1);
    wait_valid("t5_latency", 5);
    drain();

    // 6: sweep a 0..15, b 1..15, alternating requesters
    idx = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(idx[0], 4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 1'b1);
        idx++;
      end
    end
    drain();
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
